// File: rtl/m_copy.sv
// m_copy: streams a programmed number of 64-bit words from a first-word-fall-through
// source FIFO to a destination FIFO. The copy ends early if the source marks a frame end.
module m_copy (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [23:0] dc,
  input  logic        m_reset,
  output logic        m_src_getn,
  input  logic [63:0] m_src,
  input  logic        m_src_last,
  input  logic        m_src_empty,
  output logic        m_dst_putn,
  output logic [63:0] m_dst,
  output logic        m_dst_last,
  input  logic        m_dst_almost_full,
  input  logic        m_dst_full,
  output logic        busy,
  output logic        done,
  output logic        short,
  output logic [23:0] xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_rem;
  logic        r_putn;
  logic [63:0] r_dst;
  logic        r_dst_last;
  logic        r_short;
  logic [23:0] r_xfer;

  logic        w_accept;
  logic        w_pop;
  logic        w_final_pop;

  // A start is only honoured in IDLE, and an abort in the same cycle wins.
  assign w_accept = (r_state == S_IDLE) & start & ~m_reset;

  // Pop only when a word is available, the destination can take one more, and words remain.
  // An abort also blocks the pop so no source word is consumed and then thrown away.
  assign w_pop = (r_state == S_RUN) & ~m_src_empty & ~m_dst_almost_full &
                 (r_rem != 24'd0) & ~m_reset;

  // This pop closes the copy: either the count runs out or the source frame ends.
  assign w_final_pop = w_pop & ((r_rem == 24'd1) | m_src_last);

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: sequential state always uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state decode; an abort returns to IDLE from anywhere without passing through DONE.
  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    if (m_reset) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (start) w_next = (dc == 24'd0) ? S_DONE : S_RUN;
        S_RUN:   if (w_final_pop) w_next = S_FLUSH;
        S_FLUSH: w_next = S_DONE;   // the final push is on the bus during this cycle
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: capture popped word, issue the push one cycle later, track counts and status.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rem      <= 24'd0;
      r_putn     <= 1'b1;
      r_dst      <= 64'd0;
      r_dst_last <= 1'b0;
      r_short    <= 1'b0;
      r_xfer     <= 24'd0;
    end else begin
      // w_pop is already low under m_reset, so an abort leaves no push pending.
      r_putn <= ~w_pop;

      if (w_pop) begin
        r_dst      <= m_src;
        r_dst_last <= (r_rem == 24'd1) | m_src_last;
        r_rem      <= r_rem - 24'd1;   // w_pop requires r_rem != 0, so no wrap
        if (m_src_last && (r_rem > 24'd1)) r_short <= 1'b1;
      end

      // Count each word as the destination accepts it.
      if (!r_putn) r_xfer <= r_xfer + 24'd1;

      // A new copy restarts the count and status; placed last so it wins.
      if (w_accept) begin
        r_rem   <= dc;
        r_xfer  <= 24'd0;
        r_short <= 1'b0;
      end

      if (m_reset) r_rem <= 24'd0;
    end
  end

  // The almost_full gating always leaves a slot for the pending push; a full flag while
  // a push is on the bus means the destination broke that contract.
  a_no_overrun : assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
                                  !(!r_putn && m_dst_full));

  assign m_src_getn = ~w_pop;
  assign m_dst_putn = r_putn;
  assign m_dst      = r_dst;
  assign m_dst_last = r_dst_last;
  assign busy       = (r_state == S_RUN) | (r_state == S_FLUSH);
  assign done       = (r_state == S_DONE);
  assign short      = r_short;
  assign xfer_cnt   = r_xfer;

endmodule

// File: tb/tb_m_copy.sv
// tb_m_copy: table-driven copies against a FIFO model, then directed sequences for
// back-pressure, zero length, abort and asynchronous reset.
module tb_m_copy;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start;
  logic [23:0] dc;
  logic        m_reset;
  logic        m_src_getn;
  logic [63:0] m_src;
  logic        m_src_last;
  logic        m_src_empty;
  logic        m_dst_putn;
  logic [63:0] m_dst;
  logic        m_dst_last;
  logic        m_dst_almost_full;
  logic        m_dst_full;
  logic        busy;
  logic        done;
  logic        short;
  logic [23:0] xfer_cnt;

  m_copy dut (
    .wb_clk_i          (wb_clk_i),
    .wb_rst_i          (wb_rst_i),
    .start             (start),
    .dc                (dc),
    .m_reset           (m_reset),
    .m_src_getn        (m_src_getn),
    .m_src             (m_src),
    .m_src_last        (m_src_last),
    .m_src_empty       (m_src_empty),
    .m_dst_putn        (m_dst_putn),
    .m_dst             (m_dst),
    .m_dst_last        (m_dst_last),
    .m_dst_almost_full (m_dst_almost_full),
    .m_dst_full        (m_dst_full),
    .busy              (busy),
    .done              (done),
    .short             (short),
    .xfer_cnt          (xfer_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Source FIFO model and destination capture log.
  logic [63:0] src_q[$];
  logic        srcl_q[$];
  logic [63:0] got_d[$];
  logic        got_l[$];
  int          got_cyc[$];
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          act_cnt  = 0;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [23:0] dc;
    int          nwords;
    int          last_at;    // 1-based index of the word carrying last, 0 = none
    int          exp_push;
    logic        exp_short;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word(input int v, input int i);
    return {16'hDA7A, 16'(v), 32'(i) + 32'h100};
  endfunction

  task automatic refresh_src();
    m_src_empty = (src_q.size() == 0);
    m_src       = (src_q.size() > 0) ? src_q[0] : 64'd0;
    m_src_last  = (srcl_q.size() > 0) ? srcl_q[0] : 1'b0;
  endtask

  task automatic load_src(input int v, input int n, input int last_at);
    src_q.delete();
    srcl_q.delete();
    for (int i = 0; i < n; i++) begin
      src_q.push_back(word(v, i));
      srcl_q.push_back((i + 1) == last_at);
    end
    got_d.delete();
    got_l.delete();
    got_cyc.delete();
    refresh_src();
  endtask

  // Start is held for one cycle; scyc is the cycle count of the edge that samples it.
  task automatic pulse_start(input logic [23:0] d, output int scyc);
    @(negedge wb_clk_i);
    start = 1'b1;
    dc    = d;
    @(negedge wb_clk_i);
    start = 1'b0;
    scyc  = cyc;
  endtask

  task automatic wait_done(input string name, input int base);
    for (int k = 0; k < 200 && done_cnt == base; k++) @(negedge wb_clk_i);
    check({name, " done_pulses"}, 64'(done_cnt - base), 64'd1);
  endtask

  // Sample at the clock edge (pre-update values), then advance the source FIFO.
  always @(posedge wb_clk_i) begin : mon
    logic pop_now;
    cyc++;
    pop_now = !m_src_getn;
    if (!m_src_getn || !m_dst_putn) act_cnt++;
    if (!m_dst_putn) begin
      got_d.push_back(m_dst);
      got_l.push_back(m_dst_last);
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    #1;
    if (pop_now && src_q.size() > 0) begin
      void'(src_q.pop_front());
      void'(srcl_q.pop_front());
    end
    refresh_src();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int scyc;
    int base;
    int act0;
    int n;

    vecs[0] = '{dc: 24'd4, nwords: 4, last_at: 0, exp_push: 4, exp_short: 1'b0};
    vecs[1] = '{dc: 24'd8, nwords: 3, last_at: 3, exp_push: 3, exp_short: 1'b1};
    vecs[2] = '{dc: 24'd1, nwords: 1, last_at: 0, exp_push: 1, exp_short: 1'b0};
    vecs[3] = '{dc: 24'd2, nwords: 5, last_at: 0, exp_push: 2, exp_short: 1'b0};
    vecs[4] = '{dc: 24'd3, nwords: 3, last_at: 3, exp_push: 3, exp_short: 1'b0};
    vecs[5] = '{dc: 24'd5, nwords: 4, last_at: 2, exp_push: 2, exp_short: 1'b1};

    wb_rst_i          = 1'b1;
    start             = 1'b0;
    dc                = 24'd0;
    m_reset           = 1'b0;
    m_dst_almost_full = 1'b0;
    m_dst_full        = 1'b0;
    refresh_src();

    // Reset values appear without any clock edge.
    #1;
    check("rst getn", 64'(m_src_getn), 64'd1);
    check("rst putn", 64'(m_dst_putn), 64'd1);
    check("rst dst", m_dst, 64'd0);
    check("rst dst_last", 64'(m_dst_last), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst short", 64'(short), 64'd0);
    check("rst xfer_cnt", 64'(xfer_cnt), 64'd0);
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Table-driven copies with an always-ready destination.
    for (int v = 0; v < 6; v++) begin
      load_src(v, vecs[v].nwords, vecs[v].last_at);
      base = done_cnt;
      pulse_start(vecs[v].dc, scyc);
      wait_done($sformatf("v%0d", v), base);
      @(negedge wb_clk_i);
      n = got_d.size();
      check($sformatf("v%0d push_count", v), 64'(n), 64'(vecs[v].exp_push));
      for (int i = 0; i < n && i < vecs[v].exp_push; i++) begin
        check($sformatf("v%0d data[%0d]", v, i), got_d[i], word(v, i));
        check($sformatf("v%0d last[%0d]", v, i), 64'(got_l[i]), 64'(i == vecs[v].exp_push - 1));
      end
      if (n > 0) begin
        check($sformatf("v%0d back_to_back", v), 64'(got_cyc[n-1] - got_cyc[0]), 64'(n - 1));
        check($sformatf("v%0d done_after_push", v), 64'(done_cyc), 64'(got_cyc[n-1] + 1));
      end
      check($sformatf("v%0d short", v), 64'(short), 64'(vecs[v].exp_short));
      check($sformatf("v%0d xfer_cnt", v), 64'(xfer_cnt), 64'(vecs[v].exp_push));
      check($sformatf("v%0d src_left", v), 64'(src_q.size()), 64'(vecs[v].nwords - vecs[v].exp_push));
      check($sformatf("v%0d busy_after", v), 64'(busy), 64'd0);
    end

    // Zero-length copy: no FIFO activity, done on the edge after the one sampling start,
    // and short from the previous copy is cleared.
    load_src(20, 2, 0);
    act0 = act_cnt;
    base = done_cnt;
    pulse_start(24'd0, scyc);
    wait_done("dc0", base);
    check("dc0 activity", 64'(act_cnt - act0), 64'd0);
    check("dc0 done_cycle", 64'(done_cyc), 64'(scyc + 1));
    check("dc0 xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("dc0 short", 64'(short), 64'd0);
    check("dc0 src_left", 64'(src_q.size()), 64'd2);

    // Back-pressure after word 2 for 5 cycles, with an ignored start during the stall.
    load_src(10, 4, 0);
    base = done_cnt;
    pulse_start(24'd4, scyc);
    for (int k = 0; k < 20 && src_q.size() > 2; k++) @(negedge wb_clk_i);
    m_dst_almost_full = 1'b1;
    start = 1'b1;
    dc    = 24'd1;
    @(negedge wb_clk_i);
    start = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    check("af stall src_left", 64'(src_q.size()), 64'd2);
    check("af stall pushes", 64'(got_d.size()), 64'd2);
    check("af stall getn", 64'(m_src_getn), 64'd1);
    check("af stall busy", 64'(busy), 64'd1);
    check("af stall no_done", 64'(done_cnt - base), 64'd0);
    m_dst_almost_full = 1'b0;
    wait_done("af", base);
    @(negedge wb_clk_i);
    check("af push_count", 64'(got_d.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      check($sformatf("af data[%0d]", i), got_d[i], word(10, i));
      check($sformatf("af last[%0d]", i), 64'(got_l[i]), 64'(i == 3));
    end
    check("af xfer_cnt", 64'(xfer_cnt), 64'd4);

    // Abort after 5 pushes of a 16-word copy, then a normal 2-word copy.
    load_src(11, 16, 0);
    base = done_cnt;
    pulse_start(24'd16, scyc);
    for (int k = 0; k < 40 && got_d.size() < 5; k++) @(negedge wb_clk_i);
    check("abort reached_5", 64'(got_d.size() >= 5), 64'd1);
    m_reset = 1'b1;
    @(negedge wb_clk_i);
    m_reset = 1'b0;
    check("abort getn", 64'(m_src_getn), 64'd1);
    check("abort putn", 64'(m_dst_putn), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    act0 = act_cnt;
    repeat (8) @(negedge wb_clk_i);
    check("abort no_done", 64'(done_cnt - base), 64'd0);
    check("abort idle_quiet", 64'(act_cnt - act0), 64'd0);
    load_src(12, 2, 0);
    base = done_cnt;
    pulse_start(24'd2, scyc);
    wait_done("post_abort", base);
    @(negedge wb_clk_i);
    check("post_abort push_count", 64'(got_d.size()), 64'd2);
    for (int i = 0; i < 2 && i < got_d.size(); i++)
      check($sformatf("post_abort data[%0d]", i), got_d[i], word(12, i));
    check("post_abort xfer_cnt", 64'(xfer_cnt), 64'd2);

    // Asynchronous reset between edges in the middle of a copy.
    load_src(13, 8, 0);
    base = done_cnt;
    pulse_start(24'd8, scyc);
    repeat (3) @(negedge wb_clk_i);
    check("arst pre putn", 64'(m_dst_putn), 64'd0);
    #2 wb_rst_i = 1'b1;
    #1;
    check("arst getn", 64'(m_src_getn), 64'd1);
    check("arst putn", 64'(m_dst_putn), 64'd1);
    check("arst dst", m_dst, 64'd0);
    check("arst dst_last", 64'(m_dst_last), 64'd0);
    check("arst busy", 64'(busy), 64'd0);
    check("arst done", 64'(done), 64'd0);
    check("arst short", 64'(short), 64'd0);
    check("arst xfer_cnt", 64'(xfer_cnt), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (10) @(negedge wb_clk_i);
    check("arst no_done", 64'(done_cnt - base), 64'd0);
    check("arst idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
